core2axi4l: RTL and testbench

- Converts the core-side request/grant memory interface into a single AXI4-Lite master port. Ibex LSU/IF drives the core side; the AXI4-Lite side drives the interconnect toward AXI4-Lite slaves, e.g. memory behind the AXI-to-core converter.
- Allows one outstanding transaction at a time.
- Fully registered AXI outputs.

---
 rtl/core2axi4l.sv | 199 +++++++++++++++++++
 tb/tb_core2axi4l.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core2axi4l.sv
// Bridges a core-side request/grant memory port to a single AXI4-Lite master.
// One transaction in flight at a time; every AXI output comes straight from a flop.
module core2axi4l #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // core side
    input  logic                    core_req,
    output logic                    core_gnt,
    input  logic                    core_we,
    input  logic [DATA_WIDTH/8-1:0] core_be,
    input  logic [ADDR_WIDTH-1:0]   core_addr,
    input  logic [DATA_WIDTH-1:0]   core_wdata,
    output logic                    core_rvalid,
    output logic [DATA_WIDTH-1:0]   core_rdata,
    output logic                    core_err,
    // AXI4-Lite write address
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awprot,
    // AXI4-Lite write data
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    // AXI4-Lite write response
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    // AXI4-Lite read address
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]              arprot,
    // AXI4-Lite read data
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        WR_RESP,
        RESP
    } state_t;

    state_t                    r_state;
    state_t                    w_nextState;

    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_be;
    logic                      r_awDone;
    logic                      r_wDone;
    logic                      w_awDoneNext;
    logic                      w_wDoneNext;

    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      r_err;
    logic                      r_arvalid;
    logic                      r_rready;
    logic                      r_awvalid;
    logic                      r_wvalid;
    logic                      r_bready;
    logic                      r_rvalid;

    logic                      w_accept;
    logic                      w_unused;

    // Only the top bit of a response distinguishes an error (SLVERR/DECERR).
    assign w_unused = ^{rresp[0], bresp[0]};

    assign w_accept = (r_state == IDLE) && core_req;

    always_comb begin
        w_nextState  = r_state;
        w_awDoneNext = r_awDone;
        w_wDoneNext  = r_wDone;
        case (r_state)
            IDLE: begin
                if (core_req) begin
                    if (core_we) begin
                        w_nextState  = WR;
                        w_awDoneNext = 1'b0;
                        w_wDoneNext  = 1'b0;
                    end else begin
                        w_nextState = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (r_arvalid && arready) w_nextState = RD_DATA;
            end
            RD_DATA: begin
                if (rvalid) w_nextState = RESP;
            end
            WR: begin
                w_awDoneNext = r_awDone || (r_awvalid && awready);
                w_wDoneNext  = r_wDone  || (r_wvalid  && wready);
                if (w_awDoneNext && w_wDoneNext) w_nextState = WR_RESP;
            end
            WR_RESP: begin
                if (bvalid) w_nextState = RESP;
            end
            RESP: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_awDone <= 1'b0;
            r_wDone  <= 1'b0;
        end else begin
            r_awDone <= w_awDoneNext;
            r_wDone  <= w_wDoneNext;
            if (w_accept) begin
                r_addr  <= core_addr;
                r_wdata <= core_wdata;
                r_be    <= core_be;
            end
        end
    end

    // Valids/readies are precomputed from the next state so they leave a flop.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_arvalid <= (w_nextState == RD_ADDR);
            r_rready  <= (w_nextState == RD_DATA);
            r_awvalid <= (w_nextState == WR) && !w_awDoneNext;
            r_wvalid  <= (w_nextState == WR) && !w_wDoneNext;
            r_bready  <= (w_nextState == WR_RESP);
            r_rvalid  <= (w_nextState == RESP);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if ((r_state == RD_DATA) && rvalid) begin
                r_rdata <= rdata;
                r_err   <= rresp[1];
            end else if ((r_state == WR_RESP) && bvalid) begin
                r_rdata <= '0;
                r_err   <= bresp[1];
            end
        end
    end

    assign core_gnt    = w_accept;
    assign core_rvalid = r_rvalid;
    assign core_rdata  = r_rdata;
    assign core_err    = r_err;

    assign awvalid = r_awvalid;
    assign awaddr  = r_addr;
    assign awprot  = PROT;
    assign wvalid  = r_wvalid;
    assign wdata   = r_wdata;
    assign wstrb   = r_be;
    assign bready  = r_bready;
    assign arvalid = r_arvalid;
    assign araddr  = r_addr;
    assign arprot  = PROT;
    assign rready  = r_rready;

endmodule

// File: tb/tb_core2axi4l.sv
// Directed testbench for core2axi4l: drives the core port and plays an AXI4-Lite
// slave by hand, checking handshake timing and response data cycle by cycle.
module tb_core2axi4l;

    logic        aclk;
    logic        aresetn;
    logic        core_req;
    logic        core_gnt;
    logic        core_we;
    logic [3:0]  core_be;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        core_err;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int cmpCount  = 0;
    int failCount = 0;
    int gntSeen;
    int rvalidSeen;

    core2axi4l #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .PROT       (3'b100)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .core_req    (core_req),
        .core_gnt    (core_gnt),
        .core_we     (core_we),
        .core_be     (core_be),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .core_err    (core_err),
        .awvalid     (awvalid),
        .awready     (awready),
        .awaddr      (awaddr),
        .awprot      (awprot),
        .wvalid      (wvalid),
        .wready      (wready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .bvalid      (bvalid),
        .bready      (bready),
        .bresp       (bresp),
        .arvalid     (arvalid),
        .arready     (arready),
        .araddr      (araddr),
        .arprot      (arprot),
        .rvalid      (rvalid),
        .rready      (rready),
        .rdata       (rdata),
        .rresp       (rresp)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Safety net so a stuck run still reports before stopping.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        cmpCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [3:0] be);
        core_req   = req;
        core_we    = we;
        core_addr  = addr;
        core_wdata = wd;
        core_be    = be;
    endtask

    // Valid/ready outputs packed as {arvalid,awvalid,wvalid,rready,bready,core_rvalid,core_gnt}.
    function automatic logic [31:0] hsVec();
        return {25'd0, arvalid, awvalid, wvalid, rready, bready, core_rvalid, core_gnt};
    endfunction

    initial begin
        aresetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;

        // Reset state
        #1;
        checkOutput("reset_handshakes", hsVec(), 32'h0);
        checkOutput("reset_rdata", core_rdata, 32'h0);
        checkOutput("reset_err", {31'd0, core_err}, 32'h0);
        checkOutput("reset_araddr", araddr, 32'h0);
        checkOutput("reset_prot", {26'd0, awprot, arprot}, {26'd0, 3'b100, 3'b100});
        tick();
        tick();
        aresetn = 1'b1;
        tick();

        // Zero-wait read of 0x10
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        arready = 1'b1;
        #1;
        checkOutput("rd0_gnt_T", hsVec(), 32'b0000001);
        tick();
        applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0);
        #1;
        checkOutput("rd0_arvalid_T1", hsVec(), 32'b1000000);
        checkOutput("rd0_araddr", araddr, 32'h0000_0010);
        tick();
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        #1;
        checkOutput("rd0_rready_T2", hsVec(), 32'b0001000);
        tick();
        rvalid = 1'b0; arready = 1'b0; rdata = 32'h0;
        #1;
        checkOutput("rd0_rvalid_T3", hsVec(), 32'b0000010);
        checkOutput("rd0_rdata", core_rdata, 32'hDEAD_BEEF);
        checkOutput("rd0_err", {31'd0, core_err}, 32'h0);
        tick();
        checkOutput("rd0_idle_T4", hsVec(), 32'h0);

        // Read with AR accepted on the 4th cycle, SLVERR two cycles later
        applyStimulus(1'b1, 1'b0, 32'h0000_0404, 32'h0, 4'hF);
        #1;
        checkOutput("rd1_gnt", hsVec(), 32'b0000001);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            arready = (i == 3);
            #1;
            checkOutput($sformatf("rd1_arvalid_wait%0d", i), hsVec(), 32'b1000000);
            checkOutput($sformatf("rd1_araddr_wait%0d", i), araddr, 32'h0000_0404);
            tick();
        end
        arready = 1'b0;
        #1;
        checkOutput("rd1_rready_empty", hsVec(), 32'b0001000);
        tick();
        rvalid = 1'b1; rdata = 32'hCAFE_0001; rresp = 2'b10;
        #1;
        checkOutput("rd1_rready_data", hsVec(), 32'b0001000);
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        #1;
        checkOutput("rd1_resp_pulse", hsVec(), 32'b0000010);
        checkOutput("rd1_rdata", core_rdata, 32'hCAFE_0001);
        checkOutput("rd1_err", {31'd0, core_err}, 32'h1);
        tick();
        checkOutput("rd1_single_pulse", hsVec(), 32'h0);

        // Write, W accepted two cycles before AW
        applyStimulus(1'b1, 1'b1, 32'h0000_0024, 32'h1234_5678, 4'b0011);
        #1;
        checkOutput("wr0_gnt", hsVec(), 32'b0000001);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        wready = 1'b1; awready = 1'b0;
        #1;
        checkOutput("wr0_both_valid", hsVec(), 32'b0110000);
        checkOutput("wr0_awaddr", awaddr, 32'h0000_0024);
        checkOutput("wr0_wdata", wdata, 32'h1234_5678);
        checkOutput("wr0_wstrb", {28'd0, wstrb}, 32'h3);
        tick();
        wready = 1'b0;
        #1;
        checkOutput("wr0_w_dropped", hsVec(), 32'b0100000);
        tick();
        awready = 1'b1;
        #1;
        checkOutput("wr0_aw_held", hsVec(), 32'b0100000);
        checkOutput("wr0_awaddr_held", awaddr, 32'h0000_0024);
        tick();
        awready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        #1;
        checkOutput("wr0_bready", hsVec(), 32'b0000100);
        tick();
        bvalid = 1'b0;
        #1;
        checkOutput("wr0_resp_pulse", hsVec(), 32'b0000010);
        checkOutput("wr0_rdata_zero", core_rdata, 32'h0);
        checkOutput("wr0_err", {31'd0, core_err}, 32'h0);
        tick();

        // Write with AW and W in the same cycle, DECERR
        applyStimulus(1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 4'b1111);
        #1;
        checkOutput("wr1_gnt", hsVec(), 32'b0000001);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        awready = 1'b1; wready = 1'b1;
        #1;
        checkOutput("wr1_both_valid", hsVec(), 32'b0110000);
        checkOutput("wr1_wstrb", {28'd0, wstrb}, 32'hF);
        tick();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b11;
        #1;
        checkOutput("wr1_single_wr_cycle", hsVec(), 32'b0000100);
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        #1;
        checkOutput("wr1_resp_pulse", hsVec(), 32'b0000010);
        checkOutput("wr1_err", {31'd0, core_err}, 32'h1);
        checkOutput("wr1_rdata_zero", core_rdata, 32'h0);
        tick();

        // Four back-to-back reads with core_req held; rvalid held high throughout
        gntSeen = 0;
        rvalidSeen = 0;
        arready = 1'b1;
        rvalid = 1'b1;
        rresp = 2'b00;
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b1, 1'b0, 32'h0000_0100 + 32'(4 * (c / 4)), 32'h0, 4'hF);
            rdata = 32'h5000_0000 + 32'(c / 4);
            #1;
            checkOutput($sformatf("b2b_gnt_c%0d", c), {31'd0, core_gnt}, {31'd0, (c % 4) == 0});
            checkOutput($sformatf("b2b_arvalid_c%0d", c), {31'd0, arvalid}, {31'd0, (c % 4) == 1});
            checkOutput($sformatf("b2b_rvalid_c%0d", c), {31'd0, core_rvalid}, {31'd0, (c % 4) == 3});
            if ((c % 4) == 1)
                checkOutput($sformatf("b2b_araddr_c%0d", c), araddr, 32'h0000_0100 + 32'(4 * (c / 4)));
            if ((c % 4) == 3)
                checkOutput($sformatf("b2b_rdata_c%0d", c), core_rdata, 32'h5000_0000 + 32'(c / 4));
            if (core_gnt) gntSeen++;
            if (core_rvalid) rvalidSeen++;
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        checkOutput("b2b_gnt_count", 32'(gntSeen), 32'd4);
        checkOutput("b2b_rvalid_count", 32'(rvalidSeen), 32'd4);
        tick();

        // Reset in WR after AW completes but before W
        applyStimulus(1'b1, 1'b1, 32'h0000_0200, 32'h0BAD_F00D, 4'hF);
        #1;
        checkOutput("rst_gnt", hsVec(), 32'b0000001);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        awready = 1'b1; wready = 1'b0;
        #1;
        checkOutput("rst_both_valid", hsVec(), 32'b0110000);
        tick();
        awready = 1'b0;
        #1;
        checkOutput("rst_w_pending", hsVec(), 32'b0010000);
        aresetn = 1'b0;
        #1;
        checkOutput("rst_async_drop", hsVec(), 32'h0);
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("rst_no_resp%0d", i), hsVec(), 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("rst_idle_gnt", {31'd0, core_gnt}, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end

endmodule
